// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-path arbitration blocks.
// Holds the arbiter FSM encoding, AXI response/burst codes and default widths.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ID_W   = 4;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not served last wins; a single requester always wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master (0 = instruction fetch, 1 = LSU) to one-slave AXI4 read arbiter.
// Round-robin grant, held from the AR handshake until the rlast beat is accepted.
module axi_read_arbiter
    import axi_rd_pkg::*;
#(
    parameter int   ADDR_W      = DEF_ADDR_W,
    parameter int   DATA_W      = DEF_DATA_W,
    parameter int   ID_W        = DEF_ID_W,
    parameter logic FIRST_GRANT = 1'b0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic [ID_W-1:0]   m0_rid,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic [ID_W-1:0]   m1_rid,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W-1:0]   s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic [ID_W-1:0]   s_rid,
    output logic              o_busy,
    output logic              o_grant
);

    rd_state_e state, state_nxt;
    logic      grant, grant_nxt;
    logic      last_grant, last_grant_nxt;
    logic      pick_gnt, pick_vld;
    logic      ar_hs, r_done;

    rr_pick2 u_pick (
        .req   ({m1_arvalid, m0_arvalid}),
        .last  (last_grant),
        .gnt   (pick_gnt),
        .valid (pick_vld)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            grant      <= FIRST_GRANT;
            last_grant <= ~FIRST_GRANT;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Every slave/master-facing output is gated by state, so an async reset
    // silences the bus immediately without waiting for a clock edge.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        ar_hs          = 1'b0;
        r_done         = 1'b0;

        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arid     = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rlast   = 1'b0;
        m0_rid     = '0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rlast   = 1'b0;
        m1_rid     = '0;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = pick_gnt;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (grant) begin
                    s_arvalid  = m1_arvalid;
                    s_araddr   = m1_araddr;
                    s_arid     = m1_arid;
                    s_arlen    = m1_arlen;
                    s_arsize   = m1_arsize;
                    s_arburst  = m1_arburst;
                    m1_arready = s_arready;
                    ar_hs      = m1_arvalid & s_arready;
                end else begin
                    s_arvalid  = m0_arvalid;
                    s_araddr   = m0_araddr;
                    s_arid     = m0_arid;
                    s_arlen    = m0_arlen;
                    s_arsize   = m0_arsize;
                    s_arburst  = m0_arburst;
                    m0_arready = s_arready;
                    ar_hs      = m0_arvalid & s_arready;
                end
                if (ar_hs) state_nxt = DATA;
            end
            DATA: begin
                if (grant) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                    m1_rid    = s_rid;
                    s_rready  = m1_rready;
                    r_done    = s_rvalid & m1_rready & s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                    m0_rid    = s_rid;
                    s_rready  = m0_rready;
                    r_done    = s_rvalid & m0_rready & s_rlast;
                end
                // rlast alone closes the burst; beats are deliberately not counted
                if (r_done) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy  = (state != IDLE);
    assign o_grant = grant;

endmodule
